// File: rtl/game_if.sv
// Control/status bundle between a game_engine and whatever drives it.
interface game_if #(
    parameter int WIDTH   = 3,
    parameter int SCORE_W = 4,
    parameter int GAME_W  = 4
);
    logic               EN;
    logic [1:0]         CTRL;
    logic               INIT;
    logic [WIDTH-1:0]   init_val;
    logic [WIDTH-1:0]   count;
    logic               WINNER;
    logic               LOSER;
    logic               GAMEOVER;
    logic [SCORE_W-1:0] winner_score;
    logic [SCORE_W-1:0] loser_score;
    logic [1:0]         WHO;
    logic [GAME_W-1:0]  winner_games;
    logic [GAME_W-1:0]  loser_games;

    modport master (
        output EN, CTRL, INIT, init_val,
        input  count, WINNER, LOSER, GAMEOVER, winner_score, loser_score,
               WHO, winner_games, loser_games
    );
    modport slave (
        input  EN, CTRL, INIT, init_val,
        output count, WINNER, LOSER, GAMEOVER, winner_score, loser_score,
               WHO, winner_games, loser_games
    );
endinterface

// File: rtl/game_engine.sv
// Up/down counter game: edge-scored WINNER/LOSER conditions, a game ends when
// either score hits WIN_LIMIT, with saturating per-side games-won tallies.
module game_engine #(
    parameter int WIDTH     = 3,
    parameter int SCORE_W   = 4,
    parameter int WIN_LIMIT = 15,
    parameter int GAME_W    = 4
) (
    input  logic   clk,
    input  logic   rst,
    game_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_ROUND, S_OVER} state_t;

    state_t             r_state, w_state_nxt;
    logic [WIDTH-1:0]   r_count, w_count_nxt, w_step;
    logic [SCORE_W-1:0] r_wscore, r_lscore, w_wscore_nxt, w_lscore_nxt;
    logic [1:0]         r_who, w_who_nxt;
    logic [GAME_W-1:0]  r_wgames, r_lgames, w_wgames_nxt, w_lgames_nxt;
    logic               r_wprev, r_lprev;
    logic               w_winner, w_loser, w_w_hit, w_l_hit;

    assign w_winner = (r_state == S_ROUND) && (r_count == {WIDTH{1'b1}});
    assign w_loser  = (r_state == S_ROUND) && (r_count == '0);
    assign w_w_hit  = w_winner && !r_wprev;
    assign w_l_hit  = w_loser && !r_lprev;

    always_comb begin
        w_step = r_count;
        case (bus.CTRL)
            2'b00:   w_step = r_count + WIDTH'(1);
            2'b01:   w_step = r_count + WIDTH'(2);
            2'b10:   w_step = r_count - WIDTH'(1);
            default: w_step = r_count - WIDTH'(2);
        endcase
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_count_nxt  = r_count;
        w_wscore_nxt = r_wscore;
        w_lscore_nxt = r_lscore;
        w_who_nxt    = r_who;
        w_wgames_nxt = r_wgames;
        w_lgames_nxt = r_lgames;
        case (r_state)
            S_IDLE, S_OVER: begin
                if (bus.INIT) begin
                    w_state_nxt  = S_ROUND;
                    w_count_nxt  = bus.init_val;
                    w_wscore_nxt = '0;
                    w_lscore_nxt = '0;
                    w_who_nxt    = 2'b00;
                end
            end
            S_ROUND: begin
                if (bus.INIT)    w_count_nxt = bus.init_val;
                else if (bus.EN) w_count_nxt = w_step;
                // Conditions are mutually exclusive, so only one side can score.
                if (w_w_hit) begin
                    w_wscore_nxt = r_wscore + SCORE_W'(1);
                    if (r_wscore == SCORE_W'(WIN_LIMIT - 1)) begin
                        w_state_nxt  = S_OVER;
                        w_who_nxt    = 2'b10;
                        w_wgames_nxt = (r_wgames == {GAME_W{1'b1}}) ? r_wgames
                                                                     : r_wgames + GAME_W'(1);
                    end
                end else if (w_l_hit) begin
                    w_lscore_nxt = r_lscore + SCORE_W'(1);
                    if (r_lscore == SCORE_W'(WIN_LIMIT - 1)) begin
                        w_state_nxt  = S_OVER;
                        w_who_nxt    = 2'b01;
                        w_lgames_nxt = (r_lgames == {GAME_W{1'b1}}) ? r_lgames
                                                                     : r_lgames + GAME_W'(1);
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_count  <= '0;
            r_wscore <= '0;
            r_lscore <= '0;
            r_who    <= 2'b00;
            r_wgames <= '0;
            r_lgames <= '0;
            r_wprev  <= 1'b0;
            r_lprev  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_count  <= w_count_nxt;
            r_wscore <= w_wscore_nxt;
            r_lscore <= w_lscore_nxt;
            r_who    <= w_who_nxt;
            r_wgames <= w_wgames_nxt;
            r_lgames <= w_lgames_nxt;
            // Flags are zero outside ROUND, which also clears them on game start.
            r_wprev  <= w_winner;
            r_lprev  <= w_loser;
        end
    end

    assign bus.count        = r_count;
    assign bus.WINNER       = w_winner;
    assign bus.LOSER        = w_loser;
    assign bus.GAMEOVER     = (r_state == S_OVER);
    assign bus.winner_score = r_wscore;
    assign bus.loser_score  = r_lscore;
    assign bus.WHO          = r_who;
    assign bus.winner_games = r_wgames;
    assign bus.loser_games  = r_lgames;
endmodule
